// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types for the MLP training sequencer.
//   sfp / ONE / HALF : signed Q8.8 fixed-point sample type and constants
//   seq_state_t      : sequencer FSM states
//   idx_w()          : index width helper that never returns zero
package mlp_train_sequencer_pkg;

    localparam int SFP_W = 16;
    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp ONE  = 16'sh0100;
    localparam sfp HALF = 16'sh0080;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRAIN,
        S_EVAL,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    // A one-entry table still needs a one-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mlp_train_sequencer_class_compare.sv
// Combinational per-sample classification check.
//   prediction : OUTPUTS MLP predictions
//   expected   : OUTPUTS target values
//   threshold  : class boundary
//   match      : 1 when every output falls on the same side of threshold
module class_compare
    import mlp_train_sequencer_pkg::*;
#(
    parameter int OUTPUTS = 1
) (
    input  sfp [OUTPUTS-1:0] prediction,
    input  sfp [OUTPUTS-1:0] expected,
    input  sfp               threshold,
    output logic             match
);

    always_comb begin
        match = 1'b1;
        for (int o = 0; o < OUTPUTS; o++) begin
            if ((sfp'(prediction[o]) < threshold) != (sfp'(expected[o]) < threshold))
                match = 1'b0;
        end
    end

endmodule

// File: rtl/mlp_train_sequencer.sv
// Hardware training / evaluation driver for the MLP block.
// Replays a register-held dataset for num_epochs epochs; each epoch is one
// training pass then one evaluation pass whose thresholded predictions are
// counted as correct / incorrect.
//   load_*        : dataset write port (IDLE/DONE only)
//   start/abort   : run control; num_epochs, early_stop latched on start
//   threshold     : classification threshold
//   values/expected/training -> MLP, prediction <- MLP (MLP_LATENCY cycles)
//   busy/done/epoch_done/epochs_run/epoch_correct : run status
module mlp_train_sequencer
    import mlp_train_sequencer_pkg::*;
#(
    parameter int INPUTS      = 2,
    parameter int OUTPUTS     = 1,
    parameter int SAMPLES     = 4,
    parameter int EPOCH_W     = 16,
    parameter int MLP_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_en,
    input  logic [idx_w(SAMPLES)-1:0]    load_idx,
    input  sfp   [INPUTS-1:0]            load_values,
    input  sfp   [OUTPUTS-1:0]           load_expected,
    input  logic                         start,
    input  logic [EPOCH_W-1:0]           num_epochs,
    input  logic                         early_stop,
    input  logic                         abort,
    input  sfp                           threshold,
    output sfp   [INPUTS-1:0]            values,
    output sfp   [OUTPUTS-1:0]           expected,
    output logic                         training,
    input  sfp   [OUTPUTS-1:0]           prediction,
    output logic                         busy,
    output logic                         done,
    output logic                         epoch_done,
    output logic [EPOCH_W-1:0]           epochs_run,
    output logic [$clog2(SAMPLES+1)-1:0] epoch_correct
);

    localparam int IW = idx_w(SAMPLES);
    localparam int DW = idx_w(MLP_LATENCY);
    localparam int CW = $clog2(SAMPLES + 1);

    typedef struct packed {
        sfp [INPUTS-1:0]  values;
        sfp [OUTPUTS-1:0] expected;
    } sample_t;

    sample_t            ds [SAMPLES];
    seq_state_t         state;
    logic [IW-1:0]      idx;
    logic [DW-1:0]      dcnt;
    logic [CW-1:0]      cnt;
    logic [EPOCH_W-1:0] ep_target;
    logic               es_lat;

    // Evaluation tokens: valid bit plus the targets the MLP was given.
    logic [MLP_LATENCY-1:0] vld_p;
    sfp   [OUTPUTS-1:0]     tok_exp_p [MLP_LATENCY];

    logic               tok_match;
    logic               tok_hit;
    logic [CW-1:0]      cnt_nxt;
    logic [EPOCH_W-1:0] er_nxt;
    logic               run_over;

    class_compare #(.OUTPUTS(OUTPUTS)) u_cmp (
        .prediction (prediction),
        .expected   (tok_exp_p[MLP_LATENCY-1]),
        .threshold  (threshold),
        .match      (tok_match)
    );

    assign tok_hit  = vld_p[MLP_LATENCY-1] & tok_match;
    assign cnt_nxt  = cnt + CW'(tok_hit);
    assign er_nxt   = (epochs_run == '1) ? epochs_run : epochs_run + 1'b1;
    assign run_over = (er_nxt == ep_target) || (es_lat && (cnt_nxt == CW'(SAMPLES)));

    // Dataset: data only, survives reset.
    always_ff @(posedge clk) begin
        if (load_en && (state == S_IDLE || state == S_DONE) &&
            (32'(load_idx) < SAMPLES)) begin
            ds[load_idx].values   <= load_values;
            ds[load_idx].expected <= load_expected;
        end
    end

    // ---- token pipeline stage boundary: issue -> prediction valid ----
    always_ff @(posedge clk) begin
        tok_exp_p[0] <= expected;
        for (int i = 1; i < MLP_LATENCY; i++)
            tok_exp_p[i] <= tok_exp_p[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= '0;
            dcnt          <= '0;
            cnt           <= '0;
            ep_target     <= '0;
            es_lat        <= 1'b0;
            vld_p         <= '0;
            values        <= '0;
            expected      <= '0;
            training      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            epoch_done    <= 1'b0;
            epochs_run    <= '0;
            epoch_correct <= '0;
        end else begin
            epoch_done <= 1'b0;
            cnt        <= cnt_nxt;
            // A token enters for every cycle an evaluation sample is on the outputs.
            vld_p[0] <= (state == S_EVAL);
            for (int i = 1; i < MLP_LATENCY; i++)
                vld_p[i] <= vld_p[i-1];

            if (abort) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                training <= 1'b0;
                done     <= 1'b0;
                vld_p    <= '0;
                cnt      <= '0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            ep_target     <= num_epochs;
                            es_lat        <= early_stop;
                            epochs_run    <= '0;
                            epoch_correct <= '0;
                            cnt           <= '0;
                            done          <= 1'b0;
                            if (num_epochs == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state    <= S_TRAIN;
                                busy     <= 1'b1;
                                idx      <= '0;
                                values   <= ds[0].values;
                                expected <= ds[0].expected;
                                training <= 1'b1;
                            end
                        end
                    end
                    S_TRAIN: begin
                        if (idx == IW'(SAMPLES - 1)) begin
                            state    <= S_EVAL;
                            idx      <= '0;
                            values   <= ds[0].values;
                            expected <= ds[0].expected;
                            training <= 1'b0;
                        end else begin
                            idx      <= idx + 1'b1;
                            values   <= ds[idx + 1'b1].values;
                            expected <= ds[idx + 1'b1].expected;
                        end
                    end
                    S_EVAL: begin
                        if (idx == IW'(SAMPLES - 1)) begin
                            state <= S_DRAIN;
                            dcnt  <= '0;
                        end else begin
                            idx      <= idx + 1'b1;
                            values   <= ds[idx + 1'b1].values;
                            expected <= ds[idx + 1'b1].expected;
                        end
                    end
                    S_DRAIN: begin
                        // Last token retires on the final drain cycle.
                        if (dcnt == DW'(MLP_LATENCY - 1)) begin
                            epoch_correct <= cnt_nxt;
                            epochs_run    <= er_nxt;
                            epoch_done    <= 1'b1;
                            cnt           <= '0;
                            if (run_over) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state    <= S_TRAIN;
                                idx      <= '0;
                                values   <= ds[0].values;
                                expected <= ds[0].expected;
                                training <= 1'b1;
                            end
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mlp_train_sequencer.sv
module tb_mlp_train_sequencer;
    import mlp_train_sequencer_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_en;
    logic [1:0]       load_idx;
    sfp   [1:0]       load_values;
    sfp   [0:0]       load_expected;
    logic             start1, start3;
    logic [15:0]      num_epochs;
    logic             early_stop;
    logic             abort;
    sfp               threshold;
    logic             inv_mode;

    sfp   [1:0]       values1, values3;
    sfp   [0:0]       expected1, expected3;
    sfp   [0:0]       pred1, pred3;
    logic             training1, training3, busy1, busy3, done1, done3;
    logic             epoch_done1, epoch_done3;
    logic [15:0]      epochs_run1, epochs_run3;
    logic [2:0]       epoch_correct1, epoch_correct3;

    sfp   [1:0]       v_d1, v_d2;
    sfp   [0:0]       e_d1, e_d2;

    int checks = 0;
    int passes = 0;
    int pulses;

    always #5 clk = ~clk;

    mlp_train_sequencer #(.INPUTS(2), .OUTPUTS(1), .SAMPLES(4), .EPOCH_W(16), .MLP_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx),
        .load_values(load_values), .load_expected(load_expected),
        .start(start1), .num_epochs(num_epochs), .early_stop(early_stop),
        .abort(abort), .threshold(threshold),
        .values(values1), .expected(expected1), .training(training1),
        .prediction(pred1), .busy(busy1), .done(done1), .epoch_done(epoch_done1),
        .epochs_run(epochs_run1), .epoch_correct(epoch_correct1)
    );

    mlp_train_sequencer #(.INPUTS(2), .OUTPUTS(1), .SAMPLES(4), .EPOCH_W(16), .MLP_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx),
        .load_values(load_values), .load_expected(load_expected),
        .start(start3), .num_epochs(num_epochs), .early_stop(early_stop),
        .abort(abort), .threshold(threshold),
        .values(values3), .expected(expected3), .training(training3),
        .prediction(pred3), .busy(busy3), .done(done3), .epoch_done(epoch_done3),
        .epochs_run(epochs_run3), .epoch_correct(epoch_correct3)
    );

    // Latency-1 stub MLP: echoes the target, or its complement ONE-expected.
    always @(posedge clk)
        pred1[0] <= inv_mode ? sfp'(ONE - expected1[0]) : expected1[0];

    // Latency-3 stub MLP: echoes the target except for sample 2 = (ONE,0).
    always @(posedge clk) begin
        v_d1 <= values3;
        v_d2 <= v_d1;
        e_d1 <= expected3;
        e_d2 <= e_d1;
        if (v_d2[0] == ONE && v_d2[1] == 16'sh0000)
            pred3[0] <= sfp'(ONE - e_d2[0]);
        else
            pred3[0] <= e_d2[0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_idx = '0; load_values = '0; load_expected = '0;
        start1 = 1'b0; start3 = 1'b0; num_epochs = '0; early_stop = 1'b0;
        abort = 1'b0; threshold = HALF; inv_mode = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_training", 32'(training1), 32'd0);
        check("rst_values", 32'(values1), 32'd0);
        check("rst_expected", 32'(expected1), 32'd0);
        check("rst_epochs_run", 32'(epochs_run1), 32'd0);
        check("rst_epoch_correct", 32'(epoch_correct1), 32'd0);
        check("rst_epoch_done", 32'(epoch_done1), 32'd0);

        // XOR dataset: values[0] = first input, values[1] = second input
        for (int i = 0; i < 4; i++) begin
            load_en = 1'b1;
            load_idx = 2'(i);
            load_values[0] = (i >= 2) ? ONE : 16'sh0000;
            load_values[1] = (i % 2 == 1) ? ONE : 16'sh0000;
            load_expected[0] = (i == 1 || i == 2) ? ONE : 16'sh0000;
            tick();
        end
        load_en = 1'b0;

        // Test 1: three epochs, perfect predictions
        num_epochs = 16'd3; early_stop = 1'b0; inv_mode = 1'b0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 27; k++) begin
            check("t1_training", 32'(training1), 32'((k % 9) < 4));
            check("t1_busy", 32'(busy1), 32'd1);
            if (k == 1) begin
                check("t1_values_s1", 32'(values1), 32'h0100_0000);
                check("t1_expected_s1", 32'(expected1), 32'h0000_0100);
            end
            if (k == 6) check("t1_values_eval_s2", 32'(values1), 32'h0000_0100);
            if (k == 9) begin
                check("t1_ep1_run", 32'(epochs_run1), 32'd1);
                check("t1_ep1_correct", 32'(epoch_correct1), 32'd4);
            end
            if (epoch_done1) pulses++;
            tick();
        end
        if (epoch_done1) pulses++;
        check("t1_pulses", 32'(pulses), 32'd3);
        check("t1_done", 32'(done1), 32'd1);
        check("t1_busy_end", 32'(busy1), 32'd0);
        check("t1_epochs_run", 32'(epochs_run1), 32'd3);
        check("t1_epoch_correct", 32'(epoch_correct1), 32'd4);
        tick();
        check("t1_done_held", 32'(done1), 32'd1);
        check("t1_epoch_done_low", 32'(epoch_done1), 32'd0);

        // Test 2: inverted predictions, nothing correct
        num_epochs = 16'd2; inv_mode = 1'b1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        check("t2_done_cleared", 32'(done1), 32'd0);
        check("t2_run_cleared", 32'(epochs_run1), 32'd0);
        for (int k = 0; k < 18; k++) tick();
        check("t2_done", 32'(done1), 32'd1);
        check("t2_epochs_run", 32'(epochs_run1), 32'd2);
        check("t2_epoch_correct", 32'(epoch_correct1), 32'd0);

        // Test 3: early stop after first perfect epoch
        num_epochs = 16'd100; early_stop = 1'b1; inv_mode = 1'b0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        check("t3_done", 32'(done1), 32'd1);
        check("t3_busy", 32'(busy1), 32'd0);
        check("t3_epochs_run", 32'(epochs_run1), 32'd1);
        check("t3_epoch_correct", 32'(epoch_correct1), 32'd4);
        check("t3_epoch_done", 32'(epoch_done1), 32'd1);
        early_stop = 1'b0;

        // Test 4: latency 3, sample 2 misclassified
        num_epochs = 16'd2;
        start3 = 1'b1; tick(); start3 = 1'b0;
        for (int k = 0; k < 22; k++) begin
            check("t4_training", 32'(training3), 32'((k % 11) < 4));
            if (k == 11) begin
                check("t4_epoch_done", 32'(epoch_done3), 32'd1);
                check("t4_ep1_correct", 32'(epoch_correct3), 32'd3);
            end
            tick();
        end
        check("t4_done", 32'(done3), 32'd1);
        check("t4_epochs_run", 32'(epochs_run3), 32'd2);
        check("t4_epoch_correct", 32'(epoch_correct3), 32'd3);

        // Test 5: abort on second EVAL cycle of epoch 2
        num_epochs = 16'd3;
        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        check("t5_pre_busy", 32'(busy1), 32'd1);
        check("t5_pre_training", 32'(training1), 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t5_busy", 32'(busy1), 32'd0);
        check("t5_training", 32'(training1), 32'd0);
        check("t5_done", 32'(done1), 32'd0);
        check("t5_epochs_run", 32'(epochs_run1), 32'd1);
        check("t5_epoch_correct", 32'(epoch_correct1), 32'd4);
        tick();
        check("t5_stays_idle", 32'(busy1), 32'd0);
        num_epochs = 16'd1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        check("t5_restart_training", 32'(training1), 32'd1);
        check("t5_restart_busy", 32'(busy1), 32'd1);
        for (int k = 0; k < 9; k++) tick();
        check("t5_restart_done", 32'(done1), 32'd1);
        check("t5_restart_run", 32'(epochs_run1), 32'd1);
        check("t5_restart_correct", 32'(epoch_correct1), 32'd4);

        // Test 6a: zero epochs
        num_epochs = 16'd0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        check("t6a_done", 32'(done1), 32'd1);
        check("t6a_busy", 32'(busy1), 32'd0);
        check("t6a_training", 32'(training1), 32'd0);
        check("t6a_epochs_run", 32'(epochs_run1), 32'd0);
        tick();
        check("t6a_training_later", 32'(training1), 32'd0);

        // Test 6c: load while busy is ignored
        num_epochs = 16'd1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        tick(); tick();
        load_en = 1'b1; load_idx = 2'd1;
        load_values[0] = ONE; load_values[1] = ONE; load_expected[0] = 16'sh0000;
        tick();
        load_en = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("t6c_done", 32'(done1), 32'd1);
        start1 = 1'b1; tick(); start1 = 1'b0;
        tick();
        check("t6c_values_s1", 32'(values1), 32'h0100_0000);
        check("t6c_expected_s1", 32'(expected1), 32'h0000_0100);
        for (int k = 0; k < 8; k++) tick();

        // Test 6b: reset during TRAIN of epoch 2
        num_epochs = 16'd3;
        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("t6b_pre_training", 32'(training1), 32'd1);
        check("t6b_pre_run", 32'(epochs_run1), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6b_busy", 32'(busy1), 32'd0);
        check("t6b_done", 32'(done1), 32'd0);
        check("t6b_training", 32'(training1), 32'd0);
        check("t6b_values", 32'(values1), 32'd0);
        check("t6b_expected", 32'(expected1), 32'd0);
        check("t6b_epoch_done", 32'(epoch_done1), 32'd0);
        check("t6b_epochs_run", 32'(epochs_run1), 32'd0);
        check("t6b_epoch_correct", 32'(epoch_correct1), 32'd0);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
